multu_seq: RTL and testbench

- Sequential unsigned multiplier; the inverse-direction companion to the combinational unsigned divider in the multi-cycle CPU's MULTU/DIVU execution path.
- Computes a 2*WIDTH-bit product as {hi, lo} using radix-2 shift-add, one multiplier bit per cycle.
- Uses a start/busy/done handshake so the CPU control FSM can stall on busy and write HI/LO on done.

---
 rtl/multu_pkg.sv | 19 +
 rtl/multu_step.sv | 21 ++
 rtl/multu_seq.sv | 102 ++++++++++
 tb/tb_multu_seq.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/multu_pkg.sv
// Shared types and defaults for the sequential unsigned multiplier.
package multu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } multu_state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 6;

  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction

  localparam int PROD_W = prod_w(DEF_WIDTH);

endpackage

// File: rtl/multu_step.sv
// One radix-2 shift-add iteration: conditionally add mcand into the upper half,
// then shift the whole (2*WIDTH+1)-bit partial product right by one.
module multu_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH:0]  p,
  input  logic [WIDTH-1:0]  mcand,
  output logic [2*WIDTH:0]  p_next
);

  logic [WIDTH:0] upper;

  // The add keeps its carry in bit WIDTH; the shift moves it into the product.
  always_comb begin
    upper = p[2*WIDTH:WIDTH];
    if (p[0])
      upper = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
    p_next = {1'b0, upper, p[WIDTH-1:1]};
  end

endmodule

// File: rtl/multu_seq.sv
// Sequential unsigned multiplier with start/busy/done handshake.
// Optional MULTU_ZERO_BYPASS_EN: zero operands skip RUN and finish in one cycle.
module multu_seq
  import multu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int PW = prod_w(WIDTH) + 1;

  multu_state_t     state_reg;
  logic [WIDTH-1:0] mcand_reg;
  logic [PW-1:0]    p_reg;
  logic [PW-1:0]    p_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             zero_op;

`ifdef MULTU_ZERO_BYPASS_EN
  assign zero_op = (a == '0) || (b == '0);
`else
  assign zero_op = 1'b0;
`endif

  multu_step #(.WIDTH(WIDTH)) u_step (
    .p      (p_reg),
    .mcand  (mcand_reg),
    .p_next (p_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      mcand_reg <= '0;
      p_reg     <= '0;
      cnt_reg   <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          busy_reg <= 1'b0;
          done_reg <= 1'b0;
          state_reg <= IDLE;
          if (start) begin
            mcand_reg <= a;
            p_reg     <= {{(WIDTH+1){1'b0}}, b};
            cnt_reg   <= '0;
            if (zero_op) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
              hi_reg    <= '0;
              lo_reg    <= '0;
            end else begin
              state_reg <= RUN;
              busy_reg  <= 1'b1;
            end
          end
        end
        RUN: begin
          p_reg   <= p_next;
          cnt_reg <= cnt_reg + 1'b1;
          // Final iteration: publish the product on entry to DONE.
          if (cnt_reg == CNT_W'(WIDTH - 1)) begin
            state_reg <= DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            hi_reg    <= p_next[2*WIDTH-1:WIDTH];
            lo_reg    <= p_next[WIDTH-1:0];
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule

// File: tb/tb_multu_seq.sv
// Directed, table-driven bench for multu_seq (WIDTH=32); honours MULTU_ZERO_BYPASS_EN.
module tb_multu_seq;
  import multu_pkg::*;

  localparam int W = DEF_WIDTH;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int vectors = 0;
  int errors  = 0;
  logic [W-1:0] prev_hi = '0;
  logic [W-1:0] prev_lo = '0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
  } vec_t;

  vec_t tbl [10];

  multu_seq #(.WIDTH(W), .CNT_W(DEF_CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Runs one multiply. If pre_started, start was already raised in the previous DONE cycle.
  // inject_at>0 pulses an ignored start during RUN; chain_next raises start with new operands in DONE.
  task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                        input int exp_lat, input bit pre_started, input int inject_at,
                        input bit chain_next, input logic [W-1:0] na, input logic [W-1:0] nb);
    int lat;
    bit ok_busy, ok_hold;
    lat = -1;
    ok_busy = 1'b1;
    ok_hold = 1'b1;
    if (!pre_started) begin
      @(negedge clk);
      start = 1'b1; a = va; b = vb;
    end
    for (int n = 1; n <= W + 10; n++) begin
      @(negedge clk);
      if (n == 1) begin
        start = 1'b0; a = '0; b = '0;
      end
      if (inject_at > 0 && n == inject_at) begin
        start = 1'b1; a = 2; b = 2;
      end
      if (inject_at > 0 && n == inject_at + 1) begin
        start = 1'b0; a = '0; b = '0;
      end
      if (busy && done) ok_busy = 1'b0;
      if (done) begin
        lat = n;
        break;
      end
      if (!busy) ok_busy = 1'b0;
      if (hi !== prev_hi || lo !== prev_lo) ok_hold = 1'b0;
    end
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("busy_pattern", {63'd0, ok_busy}, 64'd1);
    chk("hold_during_run", {63'd0, ok_hold}, 64'd1);
    chk("hi", {32'd0, hi}, {32'd0, exp_hi});
    chk("lo", {32'd0, lo}, {32'd0, exp_lo});
    $display("op %h * %h -> hi=%h lo=%h latency=%0d", va, vb, hi, lo, lat);
    prev_hi = exp_hi;
    prev_lo = exp_lo;
    if (chain_next) begin
      start = 1'b1; a = na; b = nb;
    end else begin
      @(negedge clk);
      chk("done_pulse", {62'd0, done, busy}, 64'd0);
      chk("persist", {hi, lo}, {exp_hi, exp_lo});
    end
  endtask

  int full_lat;
  int zero_lat;

  initial begin
    full_lat = W + 1;
`ifdef MULTU_ZERO_BYPASS_EN
    zero_lat = 1;
`else
    zero_lat = W + 1;
`endif
    tbl[0] = '{32'd3,          32'd5,          32'h0000_0000, 32'h0000_000F};
    tbl[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_0001};
    tbl[2] = '{32'h0001_0000,  32'h0001_0000,  32'h0000_0001, 32'h0000_0000};
    tbl[3] = '{32'd9,          32'd9,          32'h0000_0000, 32'd81};
    tbl[4] = '{32'h8000_0000,  32'd2,          32'h0000_0001, 32'h0000_0000};
    tbl[5] = '{32'd2,          32'h8000_0000,  32'h0000_0001, 32'h0000_0000};
    tbl[6] = '{32'hFFFF_FFFF,  32'd1,          32'h0000_0000, 32'hFFFF_FFFF};
    tbl[7] = '{32'd1,          32'hFFFF_FFFF,  32'h0000_0000, 32'hFFFF_FFFF};
    tbl[8] = '{32'h0000_FFFF,  32'h0000_FFFF,  32'h0000_0000, 32'hFFFE_0001};
    tbl[9] = '{32'h0001_0000,  32'h0000_FFFF,  32'h0000_0000, 32'hFFFF_0000};

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_outputs", {busy, done, hi, lo}, 66'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_outputs", {busy, done, hi, lo}, 66'd0);

    for (int i = 0; i < 10; i++)
      run_op(tbl[i].a, tbl[i].b, tbl[i].exp_hi, tbl[i].exp_lo, full_lat, 1'b0, 0, 1'b0, '0, '0);

    // start during RUN is ignored
    run_op(32'd7, 32'd6, 32'd0, 32'd42, full_lat, 1'b0, 10, 1'b0, '0, '0);

    // back-to-back: second start accepted in the DONE cycle, no IDLE gap
    run_op(32'd3, 32'd5, 32'd0, 32'd15, full_lat, 1'b0, 0, 1'b1, 32'h0001_0000, 32'h0001_0000);
    run_op(32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, full_lat, 1'b1, 0, 1'b0, '0, '0);

    // reset mid-RUN aborts with no done pulse
    begin
      bit saw_done;
      saw_done = 1'b0;
      @(negedge clk);
      start = 1'b1; a = 9; b = 9;
      for (int n = 1; n <= 15; n++) begin
        @(negedge clk);
        if (n == 1) begin
          start = 1'b0; a = '0; b = '0;
        end
        if (done) saw_done = 1'b1;
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_no_done", {63'd0, saw_done}, 64'd0);
      chk("abort_outputs", {busy, done, hi, lo}, 66'd0);
      $display("op 9 * 9 aborted by reset -> hi=%h lo=%h busy=%b", hi, lo, busy);
      prev_hi = '0;
      prev_lo = '0;
    end
    run_op(32'd9, 32'd9, 32'd0, 32'd81, full_lat, 1'b0, 0, 1'b0, '0, '0);

    // zero operand: bypass or full-length path depending on build
    run_op(32'd0, 32'h1234, 32'd0, 32'd0, zero_lat, 1'b0, 0, 1'b0, '0, '0);
    run_op(32'h1234, 32'd0, 32'd0, 32'd0, zero_lat, 1'b0, 0, 1'b0, '0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
